// File: rtl/uart_program_loader.sv
// Boot loader: takes a framed program image from the UART byte stream, writes it
// into instruction memory as little-endian words and releases the core on a good checksum.
module uart_program_loader #(
    parameter int          DATA_LENGTH      = 32,
    parameter logic [31:0] ADDR_PROGRAM_MIN = 32'h0040_0000,
    parameter int          MAX_WORDS        = 64,
    parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
    parameter logic [24:0] TIMEOUT_CYCLES   = 25'd5_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [31:0]            mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    output logic                   mem_we,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [15:0]            word_count,
    output logic [2:0]             state_dbg
);

    // Handshake: a byte is consumed on every rising clk edge with rx_valid=1; there is
    // no backpressure. mem_we is a one-cycle strobe with mem_addr/mem_wdata stable alongside it.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

    state_t      state, state_next;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [7:0]  checksum;
    logic [23:0] shift_buf;
    logic [24:0] idle_cnt;
    logic        in_frame;
    logic        timeout;
    logic        is_sync;
    logic [15:0] len_new;

    assign in_frame  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHECK);
    // An accepted byte on the same edge always wins over the timeout.
    assign timeout   = in_frame && !rx_valid && (idle_cnt == TIMEOUT_CYCLES - 25'd1);
    assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
    assign len_new   = {rx_data, len[7:0]};
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (is_sync) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (rx_valid)     state_next = S_LEN_HI;
                else if (timeout) state_next = S_ERROR;
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    if (len_new == 16'd0 || len_new > MAX_WORDS_W) state_next = S_ERROR;
                    else                                           state_next = S_DATA;
                end else if (timeout) begin
                    state_next = S_ERROR;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (byte_idx == 2'd3 && (word_idx + 16'd1) == len) state_next = S_CHECK;
                end else if (timeout) begin
                    state_next = S_ERROR;
                end
            end
            S_CHECK: begin
                if (rx_valid) state_next = (rx_data == checksum) ? S_DONE : S_ERROR;
                else if (timeout) state_next = S_ERROR;
            end
            S_DONE:   state_next = S_DONE;
            S_ERROR:  if (is_sync) state_next = S_LEN_LO;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = in_frame;
        done     = (state == S_DONE);
        error    = (state == S_ERROR);
        core_rst = (state != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len        <= 16'd0;
            byte_idx   <= 2'd0;
            word_idx   <= 16'd0;
            checksum   <= 8'd0;
            shift_buf  <= 24'd0;
            idle_cnt   <= 25'd0;
            mem_we     <= 1'b0;
            mem_addr   <= ADDR_PROGRAM_MIN;
            mem_wdata  <= '0;
            word_count <= 16'd0;
        end else begin
            mem_we <= 1'b0;

            if (rx_valid || !in_frame || timeout) idle_cnt <= 25'd0;
            else                                  idle_cnt <= idle_cnt + 25'd1;

            if (rx_valid) begin
                case (state)
                    S_IDLE, S_ERROR: if (is_sync) word_count <= 16'd0;
                    S_LEN_LO: len[7:0] <= rx_data;
                    S_LEN_HI: begin
                        len[15:8] <= rx_data;
                        byte_idx  <= 2'd0;
                        word_idx  <= 16'd0;
                        checksum  <= 8'd0;
                    end
                    S_DATA: begin
                        checksum <= checksum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        // The word is captured straight into mem_wdata on its 4th byte,
                        // so the shift buffer is free for the next word immediately.
                        if (byte_idx == 2'd3) begin
                            mem_wdata  <= DATA_LENGTH'({rx_data, shift_buf});
                            mem_addr   <= ADDR_PROGRAM_MIN + {14'd0, word_idx, 2'b00};
                            mem_we     <= 1'b1;
                            word_idx   <= word_idx + 16'd1;
                            word_count <= word_count + 16'd1;
                        end else begin
                            shift_buf <= {rx_data, shift_buf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: nominal load, checksum/length errors,
// garbage, timeout, back-to-back bytes and mid-frame reset.
module tb_uart_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;
    logic [2:0]  state_dbg;

    int n_total = 0;
    int n_bad   = 0;
    int we_cnt  = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  frame_buf[$];

    uart_program_loader #(
        .DATA_LENGTH(32),
        .ADDR_PROGRAM_MIN(32'h0040_0000),
        .MAX_WORDS(64),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(25'd100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .core_rst(core_rst),
        .busy(busy),
        .done(done),
        .error(error),
        .word_count(word_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [63:0] e;
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", mem_addr, e[63:32]);
                check("we_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; each byte is presented for one rising edge, then `gap` idle cycles.
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame_buf.size(); i++) begin
            rx_data  = frame_buf[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic load_nominal(input logic [7:0] last);
        frame_buf = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                      8'h13, 8'h00, 8'h00, 8'h00, 8'h77};
        frame_buf[11] = last;
    endtask

    task automatic push_nominal_writes();
        exp_q.push_back({32'h0040_0000, 32'h0050_0113});
        exp_q.push_back({32'h0040_0004, 32'h0000_0013});
    endtask

    initial begin
        int base;
        do_reset();

        // Reset state
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0040_0000);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_word_count", {16'd0, word_count}, 32'd0);

        // Garbage bytes then a nominal frame with idle gaps
        frame_buf = '{8'h00, 8'hFF, 8'h5A};
        send_frame(1);
        check("garbage_busy", {31'd0, busy}, 32'd0);
        push_nominal_writes();
        load_nominal(8'h77);
        send_frame(2);
        // send_frame(2) returned 2.5 cycles after the checksum edge; done is steady there too
        check("nom_done", {31'd0, done}, 32'd1);
        check("nom_core_rst", {31'd0, core_rst}, 32'd0);
        check("nom_error", {31'd0, error}, 32'd0);
        check("nom_busy", {31'd0, busy}, 32'd0);
        check("nom_word_count", {16'd0, word_count}, 32'd2);
        check("nom_we_cnt", we_cnt, 32'd2);

        // DONE ignores further bytes, including a sync
        frame_buf = '{8'hA5, 8'h01, 8'h00};
        send_frame(0);
        check("done_sticky", {31'd0, done}, 32'd1);

        // Bad checksum, then retry from ERROR
        do_reset();
        base = we_cnt;
        push_nominal_writes();
        load_nominal(8'h78);
        send_frame(1);
        check("bad_error", {31'd0, error}, 32'd1);
        check("bad_core_rst", {31'd0, core_rst}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_we_cnt", we_cnt - base, 32'd2);
        push_nominal_writes();
        load_nominal(8'h77);
        send_frame(0);
        check("retry_done", {31'd0, done}, 32'd1);
        check("retry_error", {31'd0, error}, 32'd0);
        check("retry_word_count", {16'd0, word_count}, 32'd2);

        // Length zero
        do_reset();
        base = we_cnt;
        frame_buf = '{8'hA5, 8'h00, 8'h00};
        send_frame(1);
        check("len0_error", {31'd0, error}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_no_we", we_cnt - base, 32'd0);

        // Length 65 > MAX_WORDS
        do_reset();
        frame_buf = '{8'hA5, 8'h41, 8'h00};
        send_frame(1);
        check("len65_error", {31'd0, error}, 32'd1);

        // Length 64 accepted
        do_reset();
        frame_buf = '{8'hA5, 8'h40, 8'h00};
        send_frame(1);
        check("len64_error", {31'd0, error}, 32'd0);
        check("len64_busy", {31'd0, busy}, 32'd1);
        check("len64_state", {29'd0, state_dbg}, 32'd3);

        // Timeout boundary: 99 idle cycles stays busy, the 100th errors out
        do_reset();
        frame_buf = '{8'hA5, 8'h02, 8'h00, 8'h13};
        send_frame(0);
        repeat (99) @(negedge clk);
        check("to_minus1_busy", {31'd0, busy}, 32'd1);
        check("to_minus1_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("to_error", {31'd0, error}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);

        // Back-to-back bytes
        do_reset();
        base = we_cnt;
        push_nominal_writes();
        load_nominal(8'h77);
        send_frame(0);
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_core_rst", {31'd0, core_rst}, 32'd0);
        @(negedge clk);
        check("b2b_we_cnt", we_cnt - base, 32'd2);

        // Reset mid-frame after the 6th byte
        do_reset();
        base = we_cnt;
        frame_buf = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50};
        send_frame(0);
        #1 rst = 1'b1;
        #1;
        check("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        check("midrst_word_count", {16'd0, word_count}, 32'd0);
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_we", we_cnt - base, 32'd0);
        push_nominal_writes();
        load_nominal(8'h77);
        send_frame(1);
        check("midrst_reload_done", {31'd0, done}, 32'd1);
        check("midrst_reload_wc", {16'd0, word_count}, 32'd2);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time loader between the UART receiver and the single-cycle core's instruction memory. It holds the core in reset and takes a framed program image from the UART byte stream. It packs the bytes into little-endian 32-bit words, writes each word into instruction memory starting at the program base address, and checks a frame checksum. When the checksum matches, it releases the core to fetch from the program base address.

## Interface
Parameters:
- DATA_LENGTH, 32, instruction word width
- ADDR_PROGRAM_MIN, 32'h0040_0000, byte address of the first word written
- MAX_WORDS, 64, largest accepted word count
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 25'd5_000_000, allowed idle cycles between bytes inside a frame (100 ms at 50 MHz)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  single-cycle strobe; rx_data is valid in the same cycle
- mem_addr  out  32  instruction memory byte address
- mem_wdata  out  32  instruction word to write
- mem_we  out  1  instruction memory write enable, one-cycle pulse
- core_rst  out  1  active-high hold of core reset (drives PC/register/peripheral reset)
- busy  out  1  frame in progress (states LEN_LO through CHECK)
- done  out  1  image loaded and verified
- error  out  1  last frame rejected
- word_count  out  16  words written so far in the current frame

## Operation
States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR. A byte is accepted on any rising clk edge where rx_valid=1.

- **IDLE:** wait for SYNC_BYTE, then go to LEN_LO. All other bytes are discarded.
- **LEN_LO:** latch len[7:0], then go to LEN_HI.
- **LEN_HI:** latch len[15:8].
  - If len==0 or len>MAX_WORDS, go to ERROR.
  - Otherwise clear the byte index, word index and checksum, then go to DATA.
- **DATA:**
  - Each byte goes into the shift buffer, little-endian: byte 0 → bits [7:0], byte 3 → bits [31:24].
  - Each byte is added to an 8-bit checksum, mod 256.
  - On the 4th byte of a word, issue a write:
    - mem_wdata = assembled word
    - mem_addr = ADDR_PROGRAM_MIN + 4*word_index
    - word_index and word_count then increment.
  - After word len is written, go to CHECK.
- **CHECK:**
  - If the next byte equals the checksum, go to DONE.
  - Otherwise go to ERROR.
- **DONE:** terminal until rst. Sets done=1 and core_rst=0. All further rx bytes are ignored, because the core owns the UART from then on.
- **ERROR:**
  - Holds error=1 and core_rst=1.
  - Receiving SYNC_BYTE clears error, clears word_count and goes to LEN_LO (retry).
  - Previously written words are simply overwritten by the retry.
- **Timeout:**
  - An idle counter clears on every accepted byte and counts while in LEN_LO, LEN_HI, DATA or CHECK.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, go to ERROR.
  - The counter does not run in IDLE, DONE or ERROR.
- **Arithmetic:** the address is computed as ADDR_PROGRAM_MIN + {word_index, 2'b00} at 32 bits with no wrap check; MAX_WORDS bounds it. The checksum wraps modulo 256.

## Timing
- **Reset values:** state=IDLE, core_rst=1, mem_we=0, mem_addr=ADDR_PROGRAM_MIN, mem_wdata=0, busy=0, done=0, error=0, word_count=0, idle counter=0.
- **Reset mid-frame:** takes effect immediately (asynchronous). It aborts any partial word, suppresses any pending mem_we, and returns to IDLE with core_rst=1.
- **Write pulse:**
  - mem_we is registered. It is high for exactly one cycle, in the cycle after the edge that accepted a word's 4th byte.
  - mem_addr and mem_wdata are stable in that cycle.
  - Latency from the 4th byte's strobe to mem_we is 1 cycle.
- **Back-to-back bytes:** rx_valid may be high on consecutive cycles with no byte loss. The next word's bytes are assembled while mem_we of the previous word is high, so the buffer must not be overwritten until its write has been issued.
- **Completion:** done rises and core_rst falls in the cycle after the accepted checksum byte. error rises in the cycle after a rejecting byte or after the timeout edge.
- **Flag exclusivity:** done and error are never both 1. busy is low in DONE and ERROR.
- **Simultaneous events:** rx_valid on the same edge as a timeout takes priority (the byte is accepted and the counter clears).

## Test plan
- **Nominal load:** send A5 02 00 13 01 50 00 13 00 00 00 77.
  - Two mem_we pulses: 0x0040_0000 ← 0x0050_0113, then 0x0040_0004 ← 0x0000_0013.
  - done=1 and core_rst=0 one cycle after byte 77; word_count=2.
- **Bad checksum:** same frame ending in 78.
  - Both writes still occur; then error=1, core_rst=1, done=0.
  - Resending the full correct frame then gives done=1, error=0.
- **Length bounds:**
  - A5 00 00 → error=1 and no mem_we.
  - A5 41 00 with MAX_WORDS=64 → error=1.
  - A5 40 00 is accepted and enters DATA.
- **Garbage and timeout:**
  - Send 00 FF 5A before a valid frame; those bytes are ignored and the load succeeds.
  - Send A5 02 00 13 then idle TIMEOUT_CYCLES cycles (use TIMEOUT_CYCLES=100 in sim) → error=1 and busy=0; one cycle fewer keeps busy=1.
- **Back-to-back and reset:**
  - Nominal frame with rx_valid held high 12 consecutive cycles → identical writes and done.
  - Assert rst after the 6th byte → no further mem_we, core_rst=1, word_count=0, and a subsequent full frame loads correctly.
